oipuf_eval_ctrl: RTL and testbench
==================================

Name: oipuf_eval_ctrl

Overview:
Sequencer for one 4-line, 64-stage OIPUF delay-line array. Accepts a challenge over a valid/ready handshake and drives it onto the array's challenge bus. Fires NREP trigger pulses, sampling the synchronised race outputs once per pulse, and reports the per-line majority vote plus a per-line stability flag. It sits between the host/test logic and the PUF array, and is the only driver of the array's challenge and trigger inputs.

Parameters:
CW, 64, challenge width (number of stages).
K, 4, number of lines / response bits.
SETTLE_CYC, 4, cycles with trigger low before each pulse (challenge settle / line discharge); must be ≥1.
PROP_CYC, 8, cycles the trigger is held high before sampling; must be ≥3 to cover synchroniser latency.
NREP, 5, evaluations per challenge; odd, ≥1.

Ports:
iclk  in  1  system clock
irst_n  in  1  reset, asynchronous, active-low
ireq_valid  in  1  challenge request valid
oreq_ready  out  1  controller idle, can accept a request
iChal  in  CW  challenge, sampled on request handshake
oC  out  CW  challenge bus to PUF array (iC)
otriger  out  1  trigger to PUF array (itriger)
iTP  in  K  raw race outputs from PUF array (oTP), asynchronous
oresp_valid  out  1  response valid
iresp_ready  in  1  consumer accepts response
oResp  out  K  majority-voted response
oStable  out  K  per-line flag: all NREP samples agreed
obusy  out  1  evaluation in progress (not IDLE)

Behaviour:
- Reset (async assert, sync deassert inside block):
  - State IDLE.
  - oC=0, otriger=0, oresp_valid=0, oResp=0, oStable=0, obusy=0.
  - oreq_ready=1 once irst_n is high.
  - Repetition and vote counters cleared.
- Reset asserted mid-operation: otriger drops low immediately (asynchronously). The in-flight request is discarded and produces no response.
- oC and otriger come straight from flops, with no logic between flop and port.
- iTP passes through a 2-flop synchroniser per bit, running continuously.
- FSM states: IDLE, LOAD, FIRE, SAMPLE, VOTE, DONE.
  - IDLE: oreq_ready=1. On ireq_valid&oreq_ready: oC<=iChal, clear K ones-counters, rep<=0, go to LOAD.
  - LOAD: otriger=0 for SETTLE_CYC cycles, then go to FIRE.
  - FIRE: otriger=1 for PROP_CYC cycles, then go to SAMPLE.
  - SAMPLE (1 cycle): otriger=0. Each ones_cnt[i] += synced iTP[i]. If rep==NREP-1 go to VOTE, else rep++ and go to LOAD.
  - VOTE (1 cycle): oResp[i] <= (ones_cnt[i] > NREP/2). oStable[i] <= (ones_cnt[i]==0 or ones_cnt[i]==NREP). Go to DONE.
  - DONE: oresp_valid=1. oResp and oStable stay stable until iresp_ready. On handshake go to IDLE (oresp_valid=0 the next cycle).
- Counter widths:
  - ones_cnt: clog2(NREP+1) bits.
  - Phase counter: clog2(max(SETTLE_CYC,PROP_CYC)) bits.
  - No counter wraps within legal parameters.
- Latency, handshake at edge E0:
  - Trigger rises at E0+SETTLE_CYC.
  - oresp_valid rises at E0 + NREP*(SETTLE_CYC+PROP_CYC+1) + 1. Defaults: 66.
- Pulse count: exactly NREP otriger pulses per request, each PROP_CYC cycles wide, with ≥SETTLE_CYC low cycles between pulses.
- oC holds the last challenge after DONE until the next accept.
- oResp/oStable hold their value after the handshake until the next VOTE.
- ireq_valid is ignored outside IDLE. There is no same-cycle accept on the DONE→IDLE handshake; the earliest next accept is the cycle after.
- A change on iTP outside SAMPLE has no effect on counters.
- NREP=1: oStable is all ones.

Decomposition:
- Package oipuf_pkg:
  - FSM state enum.
  - Default values of CW, K, SETTLE_CYC, PROP_CYC, NREP.
  - Helper function for counter width (clog2).
- Sub-module puf_resp_sync: K-bit 2-flop synchroniser with async active-low reset, instantiated once for iTP.

Test Plan:
1. Reset: hold irst_n=0, then release.
   - During reset: oreq_ready=0, oC=0, otriger=0, oresp_valid=0, oResp=0, oStable=0, obusy=0.
   - After release: oreq_ready=1.
2. Single evaluation: iChal=64'hDEADBEEF_01234567, iTP tied 4'b1010.
   - oC=iChal one cycle after accept.
   - 5 otriger pulses, each 8 cycles wide.
   - oresp_valid at +66 cycles; oResp=4'b1010, oStable=4'b1111.
3. Majority vote: iTP[0] sampled 1,1,0,1,0 across the 5 SAMPLE cycles, iTP[3:1]=0.
   - oResp=4'b0001, oStable=4'b1110.
4. Backpressure: iresp_ready=0 for 10 cycles after oresp_valid, with ireq_valid=1 throughout.
   - oResp, oStable and oresp_valid hold; oreq_ready=0; no new accept.
   - After iresp_ready=1: accept occurs the cycle after the response handshake.
5. Reset mid-FIRE: pull irst_n low at cycle 7 after accept.
   - otriger=0 with no clock edge; no oresp_valid is ever produced.
   - After release: oreq_ready=1 and a fresh request completes normally.
6. Back-to-back: ireq_valid and iresp_ready held high, two challenges A then B.
   - Two responses, each 66 cycles after its accept.
   - oC switches from A to B exactly at the second accept; exactly 10 trigger pulses total.

Source files
------------

// File: rtl/oipuf_pkg.sv
// Shared types, default parameters and width helpers for the OIPUF evaluation controller.
package oipuf_pkg;

   localparam int unsigned DEF_CW         = 64;
   localparam int unsigned DEF_K          = 4;
   localparam int unsigned DEF_SETTLE_CYC = 4;
   localparam int unsigned DEF_PROP_CYC   = 8;
   localparam int unsigned DEF_NREP       = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FIRE   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_VOTE   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Bits needed to index n distinct values; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      cnt_w = (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      max_u = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/oipuf_eval_ctrl_puf_resp_sync.sv
// Multi-bit 2-flop synchroniser for the asynchronous PUF race outputs.
// Ports: clk_i/rst_ni clock and async active-low reset, async_i raw bits, sync_o synchronised bits.
module puf_resp_sync #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Free-running two-stage capture; bits are independent races so no bus coherency is needed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/oipuf_eval_ctrl.sv
// Evaluation sequencer for a K-line, CW-stage OIPUF delay-line array.
// Accepts a challenge (ireq_valid/oreq_ready), drives oC, fires NREP otriger pulses,
// samples the synchronised race outputs once per pulse and returns a per-line
// majority vote (oResp) and all-samples-agree flag (oStable) on oresp_valid/iresp_ready.
// Ports: iclk/irst_n clock and async active-low reset; iChal challenge in; oC/otriger
// array drive; iTP raw array outputs; oResp/oStable response; obusy not-idle indicator.
module oipuf_eval_ctrl
   import oipuf_pkg::*;
#(
   parameter int unsigned CW         = DEF_CW,
   parameter int unsigned K          = DEF_K,
   parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int unsigned PROP_CYC   = DEF_PROP_CYC,
   parameter int unsigned NREP       = DEF_NREP
) (
   input  logic          iclk,
   input  logic          irst_n,
   input  logic          ireq_valid,
   output logic          oreq_ready,
   input  logic [CW-1:0] iChal,
   output logic [CW-1:0] oC,
   output logic          otriger,
   input  logic [K-1:0]  iTP,
   output logic          oresp_valid,
   input  logic          iresp_ready,
   output logic [K-1:0]  oResp,
   output logic [K-1:0]  oStable,
   output logic          obusy
);

   localparam int unsigned OW = cnt_w(NREP + 1);
   localparam int unsigned PW = cnt_w(max_u(SETTLE_CYC, PROP_CYC));
   localparam int unsigned RW = cnt_w(NREP);

   state_e                 state_q, state_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic [RW-1:0]          rep_q,   rep_d;
   logic [K-1:0][OW-1:0]   ones_q,  ones_d;
   logic [CW-1:0]          chal_q,  chal_d;
   logic                   trig_q,  trig_d;
   logic                   valid_q, valid_d;
   logic [K-1:0]           resp_q,  resp_d;
   logic [K-1:0]           stab_q,  stab_d;
   logic                   ready_q, ready_d;
   logic                   busy_q,  busy_d;
   logic [K-1:0]           tp_sync;

   puf_resp_sync #(.W(K)) u_tp_sync (
      .clk_i  (iclk),
      .rst_ni (irst_n),
      .async_i(iTP),
      .sync_o (tp_sync)
   );

   // State and output registers; reset also kills any in-flight trigger pulse.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         rep_q   <= '0;
         ones_q  <= '0;
         chal_q  <= '0;
         trig_q  <= 1'b0;
         valid_q <= 1'b0;
         resp_q  <= '0;
         stab_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rep_q   <= rep_d;
         ones_q  <= ones_d;
         chal_q  <= chal_d;
         trig_q  <= trig_d;
         valid_q <= valid_d;
         resp_q  <= resp_d;
         stab_q  <= stab_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; trigger is computed one cycle early so it leaves a flop directly.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rep_d   = rep_q;
      ones_d  = ones_q;
      chal_d  = chal_q;
      trig_d  = trig_q;
      valid_d = valid_q;
      resp_d  = resp_q;
      stab_d  = stab_q;

      unique case (state_q)
         ST_IDLE: begin
            // ready_q is low for the first cycle after reset, so no accept before it shows.
            if (ireq_valid && ready_q) begin
               chal_d  = iChal;
               ones_d  = '0;
               rep_d   = '0;
               phase_d = '0;
               trig_d  = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (phase_q == PW'(SETTLE_CYC - 1)) begin
               phase_d = '0;
               trig_d  = 1'b1;
               state_d = ST_FIRE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         ST_FIRE: begin
            if (phase_q == PW'(PROP_CYC - 1)) begin
               phase_d = '0;
               trig_d  = 1'b0;
               state_d = ST_SAMPLE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         ST_SAMPLE: begin
            for (int unsigned i = 0; i < K; i++) begin
               ones_d[i] = ones_q[i] + OW'(tp_sync[i]);
            end
            if (rep_q == RW'(NREP - 1)) begin
               state_d = ST_VOTE;
            end else begin
               rep_d   = rep_q + RW'(1);
               state_d = ST_LOAD;
            end
         end
         ST_VOTE: begin
            for (int unsigned i = 0; i < K; i++) begin
               resp_d[i] = (ones_q[i] > OW'(NREP / 2));
               stab_d[i] = (ones_q[i] == '0) || (ones_q[i] == OW'(NREP));
            end
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (iresp_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            trig_d  = 1'b0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   assign oreq_ready  = ready_q;
   assign oC          = chal_q;
   assign otriger     = trig_q;
   assign oresp_valid = valid_q;
   assign oResp       = resp_q;
   assign oStable     = stab_q;
   assign obusy       = busy_q;

endmodule

// File: tb/tb_oipuf_eval_ctrl.sv
// Directed bench for oipuf_eval_ctrl with default parameters.
module tb_oipuf_eval_ctrl;

   logic        iclk;
   logic        irst_n;
   logic        ireq_valid;
   logic        oreq_ready;
   logic [63:0] iChal;
   logic [63:0] oC;
   logic        otriger;
   logic [3:0]  iTP;
   logic        oresp_valid;
   logic        iresp_ready;
   logic [3:0]  oResp;
   logic [3:0]  oStable;
   logic        obusy;

   int n_checks;
   int n_errors;

   oipuf_eval_ctrl dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .ireq_valid (ireq_valid),
      .oreq_ready (oreq_ready),
      .iChal      (iChal),
      .oC         (oC),
      .otriger    (otriger),
      .iTP        (iTP),
      .oresp_valid(oresp_valid),
      .iresp_ready(iresp_ready),
      .oResp      (oResp),
      .oStable    (oStable),
      .obusy      (obusy)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // Present a challenge and return just after the accepting edge.
   task automatic do_accept(input logic [63:0] c, input string tag);
      int n;
      iChal      = c;
      ireq_valid = 1'b1;
      n = 0;
      while (!oreq_ready && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_ready_wait"}, 64'(oreq_ready), 64'd1);
      tick();
      ireq_valid = 1'b0;
      check({tag, "_oC"}, oC, c);
      check({tag, "_ready_low"}, 64'(oreq_ready), 64'd0);
      check({tag, "_busy"}, 64'(obusy), 64'd1);
   endtask

   // Follow one evaluation from accept to oresp_valid; seq[4r+:4] is driven on iTP for repetition r.
   task automatic run_eval(input logic [19:0] seq, input logic [3:0] exp_resp,
                           input logic [3:0] exp_stab, input string tag);
      int   pulses;
      int   hi;
      int   first_rise;
      int   vcyc;
      logic prev;
      logic width_ok;
      pulses = 0; hi = 0; first_rise = -1; vcyc = -1; prev = otriger; width_ok = 1'b1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         tick();
         if (otriger && !prev) begin
            if (pulses == 0) first_rise = cyc;
            if (pulses < 5) iTP = seq[4*pulses +: 4];
            pulses++;
            hi = 0;
         end
         if (otriger) hi++;
         if (!otriger && prev && hi != 8) width_ok = 1'b0;
         prev = otriger;
         if (oresp_valid) begin
            vcyc = cyc;
            break;
         end
      end
      check({tag, "_trig_rise"}, 64'(first_rise), 64'd4);
      check({tag, "_pulses"}, 64'(pulses), 64'd5);
      check({tag, "_width"}, 64'(width_ok), 64'd1);
      check({tag, "_latency"}, 64'(vcyc), 64'd66);
      check({tag, "_resp"}, 64'(oResp), 64'(exp_resp));
      check({tag, "_stable"}, 64'(oStable), 64'(exp_stab));
   endtask

   initial begin
      logic [63:0] ca, cb, cc;
      int   pulses, v1, v2, bsw, vcnt, seen;
      logic prev;

      n_checks = 0; n_errors = 0;
      irst_n = 1'b0; ireq_valid = 1'b0; iresp_ready = 1'b0; iChal = '0; iTP = '0;

      // 1. reset values
      #12;
      check("rst_ready", 64'(oreq_ready), 64'd0);
      check("rst_oC", oC, 64'd0);
      check("rst_trig", 64'(otriger), 64'd0);
      check("rst_valid", 64'(oresp_valid), 64'd0);
      check("rst_resp", 64'(oResp), 64'd0);
      check("rst_stable", 64'(oStable), 64'd0);
      check("rst_busy", 64'(obusy), 64'd0);
      @(negedge iclk);
      irst_n = 1'b1;
      tick();
      check("post_rst_ready", 64'(oreq_ready), 64'd1);

      // 2. single evaluation, constant race outcome
      ca  = 64'hDEADBEEF_01234567;
      iTP = 4'b1010;
      do_accept(ca, "t2");
      run_eval({5{4'b1010}}, 4'b1010, 4'b1111, "t2");
      iresp_ready = 1'b1;
      tick();
      iresp_ready = 1'b0;
      check("t2_valid_drop", 64'(oresp_valid), 64'd0);
      check("t2_ready_back", 64'(oreq_ready), 64'd1);
      check("t2_resp_hold", 64'(oResp), 64'h0A);
      check("t2_oC_hold", oC, ca);

      // 3. majority vote: line 0 sees 1,1,0,1,0
      cb = 64'h0123_4567_89AB_CDEF;
      do_accept(cb, "t3");
      run_eval(20'h01011, 4'b0001, 4'b1110, "t3");

      // 4. backpressure with a pending request
      cc = 64'hA5A5_5A5A_F00F_0FF0;
      iChal = cc;
      ireq_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_valid_hold", 64'(oresp_valid), 64'd1);
         check("t4_resp_hold", 64'(oResp), 64'h1);
         check("t4_stab_hold", 64'(oStable), 64'hE);
         check("t4_no_ready", 64'(oreq_ready), 64'd0);
         check("t4_no_accept", oC, cb);
      end
      iresp_ready = 1'b1;
      tick();
      iresp_ready = 1'b0;
      check("t4_hs_valid", 64'(oresp_valid), 64'd0);
      check("t4_hs_ready", 64'(oreq_ready), 64'd1);
      check("t4_hs_no_same_cycle", oC, cb);
      tick();
      ireq_valid = 1'b0;
      check("t4_accept_oC", oC, cc);
      check("t4_accept_ready", 64'(oreq_ready), 64'd0);
      run_eval({5{4'b0110}}, 4'b0110, 4'b1111, "t4");
      iresp_ready = 1'b1;
      tick();
      iresp_ready = 1'b0;

      // 5. reset while the trigger is high
      do_accept(ca, "t5");
      for (int i = 0; i < 6; i++) tick();
      check("t5_trig_before", 64'(otriger), 64'd1);
      #2;
      irst_n = 1'b0;
      #1;
      check("t5_trig_async", 64'(otriger), 64'd0);
      check("t5_busy_rst", 64'(obusy), 64'd0);
      check("t5_ready_rst", 64'(oreq_ready), 64'd0);
      repeat (3) @(negedge iclk);
      irst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (oresp_valid || otriger) seen++;
      end
      check("t5_no_resp", 64'(seen), 64'd0);
      check("t5_ready_after", 64'(oreq_ready), 64'd1);
      iTP = 4'b0011;
      do_accept(cb, "t5b");
      run_eval({5{4'b0011}}, 4'b0011, 4'b1111, "t5b");
      iresp_ready = 1'b1;
      tick();
      iresp_ready = 1'b0;

      // 6. back-to-back with both handshakes held high
      iChal = ca; ireq_valid = 1'b1; iresp_ready = 1'b1;
      tick();
      check("t6_a_oC", oC, ca);
      iChal = cc;
      pulses = 0; v1 = -1; v2 = -1; bsw = -1; vcnt = 0; prev = otriger;
      for (int cyc = 1; cyc <= 150; cyc++) begin
         tick();
         if (otriger && !prev) pulses++;
         prev = otriger;
         if (oresp_valid) begin
            vcnt++;
            if (v1 < 0) v1 = cyc;
            else if (v2 < 0) v2 = cyc;
         end
         if (bsw < 0 && oC == cc) begin
            bsw = cyc;
            ireq_valid = 1'b0;
         end
      end
      iresp_ready = 1'b0;
      check("t6_resp_a", 64'(v1), 64'd66);
      check("t6_switch_b", 64'(bsw), 64'd68);
      check("t6_resp_b", 64'(v2), 64'd134);
      check("t6_valid_cycles", 64'(vcnt), 64'd2);
      check("t6_pulses", 64'(pulses), 64'd10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
